fifo_rd_streamer: RTL and testbench

Read-side engine that drains words from the team's synchronous FIFO (rd_en / empty / data_out / underflow) and presents them on a valid/ready stream. It issues a host-programmed burst of reads and absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer. Words are delivered in FIFO order, with no loss or duplication under arbitrary downstream backpressure. It sits between the FIFO's read port and any consumer, and is the counterpart of the FIFO write-side stimulus.

---
 rtl/fifo_rd_streamer_pkg.sv | 13 +
 rtl/fifo_rd_streamer_if.sv | 22 ++
 rtl/fifo_rd_streamer_skid_buf.sv | 50 +++++
 rtl/fifo_rd_streamer.sv | 85 ++++++++
 tb/tb_fifo_rd_streamer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_streamer_pkg.sv
// Shared types and constants for the FIFO read-side streamer.
package fifo_rd_streamer_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN,
        RD_DONE
    } rd_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for the streamer.
interface fifo_rd_streamer_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  rd_en;
    logic                  empty;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  underflow;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output rd_en, m_data, m_valid,
        input  empty, data_out, underflow, m_ready
    );

    modport slave (
        input  rd_en, m_data, m_valid,
        output empty, data_out, underflow, m_ready
    );
endinterface

// File: rtl/fifo_rd_streamer_skid_buf.sv
// Two-entry in-order skid buffer; absorbs the FIFO read latency ahead of the stream.
module rd_skid_buf
    import fifo_rd_streamer_pkg::*;
#(
    parameter int FIFO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [FIFO_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occupancy,
    output logic [FIFO_WIDTH-1:0] head,
    output logic                  valid
);
    logic [FIFO_WIDTH-1:0] slot0;
    logic [FIFO_WIDTH-1:0] slot1;
    logic                  pop_eff;
    logic                  push_eff;

    assign valid    = (occupancy != 2'd0);
    assign pop_eff  = pop && valid;
    assign push_eff = push && (pop_eff || (occupancy < 2'(SKID_DEPTH)));
    assign head     = valid ? slot0 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= 2'd0;
        end else if (push_eff && !pop_eff) begin
            occupancy <= occupancy + 2'd1;
        end else if (!push_eff && pop_eff) begin
            occupancy <= occupancy - 2'd1;
        end
    end

    // Slot contents are qualified by occupancy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (pop_eff) begin
            slot0 <= (push_eff && occupancy == 2'd1) ? push_data : slot1;
            slot1 <= push_data;
        end else if (push_eff) begin
            if (occupancy == 2'd0) begin
                slot0 <= push_data;
            end else begin
                slot1 <= push_data;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Burst read engine: drains the FIFO read port into a valid/ready stream.
module fifo_rd_streamer
    import fifo_rd_streamer_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic                 abort,
    fifo_rd_streamer_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 underflow_err,
    output logic [CNT_W-1:0]     word_count
);
    rd_state_e        state;
    rd_state_e        state_next;
    logic [CNT_W-1:0] remaining;
    logic             inflight;
    logic [1:0]       occupancy;
    logic             start_ok;
    logic             push;
    logic             xfer;

    assign start_ok = (state == RD_IDLE) && start;
    assign push     = inflight && !bus.underflow;
    assign xfer     = bus.m_valid && bus.m_ready;

    // Counting the in-flight word guarantees a slot exists when its data lands.
    assign bus.rd_en = (state == RD_RUN) && !abort && !bus.empty &&
                       (remaining != '0) &&
                       (({1'b0, occupancy} + {2'b00, inflight}) < 3'(SKID_DEPTH));

    always_comb begin
        state_next = state;
        busy       = (state != RD_IDLE);
        done       = (state == RD_DONE);
        unique case (state)
            RD_IDLE:  if (start) state_next = (burst_len != '0) ? RD_RUN : RD_DONE;
            RD_RUN:   if (abort || (bus.rd_en && remaining == CNT_W'(1))) state_next = RD_DRAIN;
            RD_DRAIN: if (!inflight && occupancy == 2'd0) state_next = RD_DONE;
            RD_DONE:  state_next = RD_IDLE;
            default:  state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RD_IDLE;
            remaining     <= '0;
            inflight      <= 1'b0;
            word_count    <= '0;
            underflow_err <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= bus.rd_en;
            if (start_ok) begin
                remaining     <= burst_len;
                word_count    <= '0;
                underflow_err <= 1'b0;
            end else begin
                if (bus.rd_en) remaining <= remaining - CNT_W'(1);
                if (xfer) word_count <= word_count + CNT_W'(1);
                if (inflight && bus.underflow) underflow_err <= 1'b1;
            end
        end
    end

    rd_skid_buf #(
        .FIFO_WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.data_out),
        .pop       (bus.m_ready),
        .occupancy (occupancy),
        .head      (bus.m_data),
        .valid     (bus.m_valid)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT and predicts the stream.
module tb_fifo_rd_streamer;
    localparam int W  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort;
    logic [CW-1:0] burst_len = '0;
    logic          busy;
    logic          done;
    logic          underflow_err;
    logic [CW-1:0] word_count;

    fifo_rd_streamer_if #(.FIFO_WIDTH(W)) bus ();

    fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .burst_len     (burst_len),
        .abort         (abort),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .underflow_err (underflow_err),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] next_word = 16'h0001;
    logic [W-1:0] w;
    int  occ_m = 0;
    bit  infl_m = 0;
    bit  rd_seen = 0;
    bit  xfer_seen = 0;
    bit  prev_stall = 0;
    logic [W-1:0] prev_data;
    int  rd_cnt = 0, uf_cnt = 0, xfer_cnt = 0, done_cnt = 0;
    int  abort_at = 0, uf_at = 0, ready_mode = 0;
    bit  tog = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // FIFO + downstream model, acting just after each rising edge.
    initial begin
        bus.empty = 1'b1; bus.data_out = '0; bus.underflow = 1'b0; bus.m_ready = 1'b0; abort = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                exp_q.delete(); occ_m = 0; infl_m = 0; bus.underflow = 1'b0; abort = 1'b0;
            end else begin
                if (infl_m && !bus.underflow) occ_m++;
                if (xfer_seen) occ_m--;
                infl_m = rd_seen;
                abort = 1'b0;
                bus.underflow = 1'b0;
                bus.data_out = W'($urandom);
                if (rd_seen) begin
                    rd_cnt++;
                    w = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
                    bus.data_out = w;
                    if (rd_cnt == uf_at) begin
                        bus.underflow = 1'b1; uf_cnt++;
                    end else begin
                        exp_q.push_back(w);
                    end
                    if (rd_cnt == abort_at) abort = 1'b1;
                end
            end
            bus.empty = (fifo_q.size() == 0);
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: begin tog = !tog; bus.m_ready = tog; end
                2: bus.m_ready = 1'($urandom);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor on the falling edge: stream scoreboard and read-request rules.
    initial begin
        forever begin
            @(negedge clk);
            rd_seen = 0; xfer_seen = 0;
            if (rst_n) begin
                if (done) done_cnt++;
                chk("m_valid_vs_buffer", bus.m_valid, occ_m != 0);
                if (prev_stall) begin
                    chk("stall_valid_hold", bus.m_valid, 1);
                    chk("stall_data_hold", bus.m_data, prev_data);
                end
                if (bus.rd_en) begin
                    chk("rd_en_while_empty", bus.empty, 0);
                    chk("rd_en_no_space", (occ_m + int'(infl_m)) < 2, 1);
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_word");
                    else chk("stream_data", bus.m_data, exp_q.pop_front());
                    xfer_cnt++;
                end
                rd_seen    = bus.rd_en;
                xfer_seen  = bus.m_valid && bus.m_ready;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end else begin
                prev_stall = 0;
            end
        end
    end

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
    endtask

    task automatic run_burst(input int len, input int pre, input int refill_at, input int refill_n,
                             input int rmode, input int ab, input int uf_pos, input int exp_reads,
                             input bit poke);
        int rd0, uf0, x0, d0, exp_wc;
        bit ok, exp_uf;
        exp_uf = (uf_pos != 0) && (uf_pos <= exp_reads);
        exp_wc = exp_reads - (exp_uf ? 1 : 0);
        preload(pre);
        rd0 = rd_cnt; uf0 = uf_cnt; x0 = xfer_cnt; d0 = done_cnt;
        abort_at   = (ab != 0) ? rd0 + ab : 0;
        uf_at      = (uf_pos != 0) ? rd0 + uf_pos : 0;
        ready_mode = rmode;
        @(posedge clk); #2;
        burst_len = CW'(len); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        if (len == 0) begin
            @(negedge clk); #1;
            chk("zero_len_done", done, 1);
            chk("zero_len_no_rd", bus.rd_en, 0);
            @(posedge clk); #2;
        end
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            if (done_cnt != d0) begin ok = 1; break; end
            if (c == refill_at) preload(refill_n);
            if (poke && c == 3) begin burst_len = CW'(1); start = 1'b1; end
            if (poke && c == 4) start = 1'b0;
            @(posedge clk); #2;
        end
        start = 1'b0;
        if (!ok) fail_now("done_timeout");
        repeat (2) begin @(posedge clk); #2; end
        chk("reads_issued", rd_cnt - rd0, exp_reads);
        chk("word_count", word_count, exp_wc);
        chk("transfers", xfer_cnt - x0, exp_wc);
        chk("done_pulses", done_cnt - d0, 1);
        chk("underflow_err", underflow_err, exp_uf);
        chk("busy_after_done", busy, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int len, pre, ab, ufp, reads;
        ready_mode = 0;
        #3;
        chk("reset_rd_en", bus.rd_en, 0);
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_data", bus.m_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_underflow_err", underflow_err, 0);
        chk("reset_word_count", word_count, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_burst(5, 5, -1, 0, 0, 0, 0, 5, 0);   // straight burst, always ready
        run_burst(5, 5, -1, 0, 1, 0, 0, 5, 1);   // toggling ready, start poked while busy
        run_burst(4, 2, 10, 2, 0, 0, 0, 4, 0);   // FIFO runs dry, refilled later
        run_burst(8, 8, -1, 0, 0, 3, 0, 3, 0);   // abort after third read
        run_burst(3, 3, -1, 0, 0, 0, 2, 3, 0);   // second word underflows

        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(1, 10);
            pre = $urandom_range(0, len);
            ab  = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : 0;
            reads = (ab != 0) ? ab : len;
            ufp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, reads) : 0;
            run_burst(len, pre, $urandom_range(2, 20), len - pre, 2, ab, ufp, reads, 0);
        end

        // Reset while the buffer is full and the stream is stalled.
        fifo_q.delete();
        preload(6);
        ready_mode = 3;
        @(posedge clk); #2;
        burst_len = CW'(6); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 50 && occ_m != 2; c++) begin @(posedge clk); #2; end
        chk("buffer_full_before_reset", occ_m, 2);
        rst_n = 1'b0;
        #1;
        chk("midreset_m_valid", bus.m_valid, 0);
        chk("midreset_rd_en", bus.rd_en, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_m_data", bus.m_data, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        fifo_q.delete();
        run_burst(0, 0, -1, 0, 0, 0, 0, 0, 0);
        run_burst(3, 3, -1, 0, 2, 0, 0, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
